// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the host-side position-command UART link.
package uart_cmd_pkg;

    localparam int CLK_HZ           = 27_000_000;
    localparam int BAUD             = 115_200;
    localparam int CLKS_PER_BIT_DEF = CLK_HZ / BAUD;

    localparam logic [7:0] CMD_BASE = 8'h30;
    localparam logic [7:0] ACK_BYTE = 8'h4B;

    // Host FSM encoding kept as plain constants so older tooling can decode it.
    typedef logic [2:0] host_state_t;
    localparam host_state_t S_IDLE     = 3'd0;
    localparam host_state_t S_TX_START = 3'd1;
    localparam host_state_t S_TX_DATA  = 3'd2;
    localparam host_state_t S_TX_STOP  = 3'd3;
    localparam host_state_t S_WAIT_ACK = 3'd4;
    localparam host_state_t S_DONE     = 3'd5;
    localparam host_state_t S_FAIL     = 3'd6;

    typedef struct packed {
        logic       valid;
        logic       frame_err;
        logic [7:0] data;
    } rx_byte_t;

endpackage

// File: rtl/uart_cmd_host_if.sv
// Command handshake and status bundle between a requester and uart_cmd_host.
interface uart_cmd_host_if;

    logic       cmd_valid;
    logic [2:0] cmd_state;
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic       fail;

    modport master (
        output cmd_valid, cmd_state,
        input  cmd_ready, busy, done, fail
    );

    modport slave (
        input  cmd_valid, cmd_state,
        output cmd_ready, busy, done, fail
    );

endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte strobe with frame check.
module uart_byte_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rx,
    output rx_byte_t rx_out
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    logic             sync1_q, sync2_q, prev_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    rx_byte_t         out_q, out_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        out_d   = out_q;
        out_d.valid = 1'b0;
        case (state_q)
            R_IDLE: begin
                // prev_q keeps a line stuck low after a framing error from retriggering
                if (!sync2_q && prev_q) begin
                    state_d = R_START;
                    cnt_d   = '0;
                end
            end
            R_START: begin
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? R_IDLE : R_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = R_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d           = '0;
                    out_d.valid     = 1'b1;
                    out_d.frame_err = ~sync2_q;
                    out_d.data      = shift_q;
                    state_d         = R_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= R_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            out_q   <= out_d;
        end
    end

    assign rx_out = out_q;

endmodule

// File: rtl/uart_cmd_host.sv
// Sends one ASCII position command over 8N1 and waits for the 'K' acknowledge with timeout and retry.
module uart_cmd_host
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int ACK_TIMEOUT  = 27_000_000,
    parameter int MAX_RETRY    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_cmd_host_if.slave  host,
    input  logic            rx,
    output logic            tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int TMR_W = $clog2(ACK_TIMEOUT) + 1;
    localparam int RTY_W = $clog2(MAX_RETRY + 1) + 1;

    host_state_t      state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [7:0]       cmd_byte_q, cmd_byte_d;
    logic             tx_q, tx_d;
    logic             bit_end, ack_hit;
    rx_byte_t         rx_out;

    uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx     (rx),
        .rx_out (rx_out)
    );

    assign bit_end = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign ack_hit = rx_out.valid && !rx_out.frame_err && (rx_out.data == ACK_BYTE);

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        cmd_byte_d = cmd_byte_q;
        case (state_q)
            S_IDLE: begin
                if (host.cmd_valid) begin
                    cmd_byte_d = CMD_BASE + {5'd0, host.cmd_state};
                    clk_cnt_d  = '0;
                    state_d    = S_TX_START;
                end
            end
            S_TX_START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = S_TX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_TX_DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) state_d   = S_TX_STOP;
                    else                   bit_idx_d = bit_idx_q + 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_TX_STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    timer_d   = '0;
                    state_d   = S_WAIT_ACK;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_WAIT_ACK: begin
                // an ACK landing on the expiry cycle takes priority over the retry
                if (ack_hit) begin
                    state_d = S_DONE;
                end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    if (retry_q < RTY_W'(MAX_RETRY)) begin
                        retry_d   = retry_q + 1'b1;
                        clk_cnt_d = '0;
                        state_d   = S_TX_START;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                retry_d = '0;
                state_d = S_IDLE;
            end
        endcase

        // tx is registered from the next state so the start bit appears right after accept
        case (state_d)
            S_TX_START: tx_d = 1'b0;
            S_TX_DATA:  tx_d = cmd_byte_d[bit_idx_d];
            default:    tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            timer_q    <= '0;
            retry_q    <= '0;
            cmd_byte_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            cmd_byte_q <= cmd_byte_d;
            tx_q       <= tx_d;
        end
    end

    assign tx             = tx_q;
    assign host.cmd_ready = (state_q == S_IDLE);
    assign host.busy      = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);
    assign host.done      = (state_q == S_DONE);
    assign host.fail      = (state_q == S_FAIL);

endmodule

// File: tb/tb_uart_cmd_host.sv
// Directed and randomized checks of uart_cmd_host against a frame-level model of the command link.
module tb_uart_cmd_host;
    import uart_cmd_pkg::*;

    localparam int CPB   = 8;
    localparam int AT    = 200;
    localparam int MR    = 2;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic tx;

    uart_cmd_host_if hif();

    uart_cmd_host #(.CLKS_PER_BIT(CPB), .ACK_TIMEOUT(AT), .MAX_RETRY(MR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (hif),
        .rx    (rx),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] tx_bytes[$];
    int tx_starts[$];
    int done_cnt = 0, fail_cnt = 0, done_cyc = 0, fail_cyc = 0, rxv_cnt = 0;
    bit pb = 0, pd = 0, pf = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // tx line decoder: one entry per complete frame, each bit must hold CPB cycles
    initial begin : tx_mon
        logic [9:0] bits;
        bit ok, aborted;
        int st;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                st = cyc; ok = 1; aborted = 0; bits = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int k = 0; k < CPB; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (!rst_n) aborted = 1;
                        if (k == 0) bits[b] = tx;
                        else if (tx !== bits[b]) ok = 0;
                    end
                end
                if (!aborted) begin
                    chk("tx_bit_width", 32'(ok), 1);
                    chk("tx_start_stop", {30'd0, bits[9], bits[0]}, 2);
                    tx_bytes.push_back(bits[8:1]);
                    tx_starts.push_back(st);
                end
            end
        end
    end

    initial begin : pulse_mon
        forever begin
            @(negedge clk);
            if (hif.done === 1'b1) begin
                done_cnt++; done_cyc = cyc;
                chk("done_busy_low", 32'(hif.busy), 0);
                chk("busy_before_done", 32'(pb), 1);
                chk("done_single", 32'(pd), 0);
            end
            if (hif.fail === 1'b1) begin
                fail_cnt++; fail_cyc = cyc;
                chk("fail_busy_low", 32'(hif.busy), 0);
                chk("fail_single", 32'(pf), 0);
            end
            if (dut.rx_out.valid === 1'b1) rxv_cnt++;
            pb = hif.busy; pd = hif.done; pf = hif.fail;
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        logic [9:0] bits;
        bits = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            tick(CPB);
        end
        rx = 1'b1;
        tick(CPB);
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (tx_bytes.size() < n && t < FRAME + AT + 50) begin
            @(negedge clk);
            t++;
        end
        chk("frame_arrival", 32'(tx_bytes.size() >= n), 1);
    endtask

    task automatic wait_outcome(input int base);
        int t = 0;
        while (done_cnt + fail_cnt <= base && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("outcome_arrival", 32'(done_cnt + fail_cnt > base), 1);
    endtask

    // Model: the same byte is sent once per attempt, attempts start FRAME+AT apart,
    // ACK on attempt k (k <= MR+1) ends in done, otherwise fail after the last wait.
    task automatic do_cmd(input logic [2:0] st, input int ack_at, input int dly);
        int f0, d0, fl0, acc, nexp;
        f0 = tx_bytes.size(); d0 = done_cnt; fl0 = fail_cnt;
        chk("ready_idle", 32'(hif.cmd_ready), 1);
        hif.cmd_state = st; hif.cmd_valid = 1'b1; acc = cyc + 1;
        @(negedge clk);
        hif.cmd_valid = 1'b0; hif.cmd_state = 3'($urandom);
        chk("tx_low_after_accept", 32'(tx), 0);
        chk("busy_after_accept", 32'(hif.busy), 1);
        chk("ready_low_busy", 32'(hif.cmd_ready), 0);
        for (int a = 1; a <= MR + 1; a++) begin
            wait_frames(f0 + a);
            if (a == ack_at && tx_bytes.size() >= f0 + a) begin
                wait_until(tx_starts[f0 + a - 1] + FRAME + dly);
                send_rx(ACK_BYTE, 1'b1);
                break;
            end
        end
        wait_outcome(d0 + fl0);
        nexp = (ack_at <= MR + 1) ? ack_at : MR + 1;
        chk("frame_count", tx_bytes.size() - f0, nexp);
        for (int i = 0; i < nexp && f0 + i < tx_bytes.size(); i++) begin
            chk("frame_byte", tx_bytes[f0 + i], CMD_BASE + 8'(st));
            if (i == 0) chk("first_start", tx_starts[f0], acc);
            else chk("retry_spacing", tx_starts[f0 + i] - tx_starts[f0 + i - 1], FRAME + AT);
        end
        chk("done_delta", done_cnt - d0, (ack_at <= MR + 1) ? 1 : 0);
        chk("fail_delta", fail_cnt - fl0, (ack_at <= MR + 1) ? 0 : 1);
        if (ack_at > MR + 1 && tx_bytes.size() > f0)
            chk("fail_time", fail_cyc, tx_starts[tx_bytes.size() - 1] + FRAME + AT);
        tick(2);
        chk("ready_after", 32'(hif.cmd_ready), 1);
        chk("busy_after", 32'(hif.busy), 0);
    endtask

    initial begin : main
        int f0, d0, fl0, r0, s;
        logic [2:0] st;
        hif.cmd_valid = 1'b0; hif.cmd_state = 3'd0;
        tick(3);
        chk("rst_tx", 32'(tx), 1);
        chk("rst_ready", 32'(hif.cmd_ready), 1);
        chk("rst_busy", 32'(hif.busy), 0);
        chk("rst_done", 32'(hif.done), 0);
        chk("rst_fail", 32'(hif.fail), 0);
        rst_n = 1'b1;
        tick(3);

        do_cmd(3'd5, 1, 20);                 // 8'h35, ACK 20 cycles after stop
        do_cmd(3'($urandom), 1, 70);         // ACK lands mid-window
        do_cmd(3'($urandom), 1, 120);        // ACK strobe on the expiry cycle
        do_cmd(3'd3, MR + 2, 0);             // no reply: three sends then fail
        do_cmd(3'($urandom), 2, 32'($urandom_range(0, 100)));
        for (int i = 0; i < 4; i++)
            do_cmd(3'($urandom), 32'($urandom_range(1, 4)), 32'($urandom_range(0, 100)));

        // wrong byte then corrupted ACK in the first window, good ACK on the retry
        st = 3'($urandom); f0 = tx_bytes.size(); d0 = done_cnt; fl0 = fail_cnt;
        hif.cmd_state = st; hif.cmd_valid = 1'b1;
        @(negedge clk);
        hif.cmd_valid = 1'b0;
        wait_frames(f0 + 1);
        s = tx_starts[f0] + FRAME;
        wait_until(s);
        r0 = rxv_cnt;
        send_rx(8'h4A, 1'b1);
        send_rx(ACK_BYTE, 1'b0);
        tick(4);
        chk("bad_bytes_seen", rxv_cnt - r0, 2);
        chk("bad_bytes_no_done", done_cnt - d0, 0);
        wait_frames(f0 + 2);
        chk("bad_resend_byte", tx_bytes[f0 + 1], CMD_BASE + 8'(st));
        chk("bad_resend_time", tx_starts[f0 + 1] - tx_starts[f0], FRAME + AT);
        wait_until(tx_starts[f0 + 1] + FRAME + 5);
        send_rx(ACK_BYTE, 1'b1);
        wait_outcome(d0 + fl0);
        chk("bad_then_done", done_cnt - d0, 1);
        chk("bad_frames", tx_bytes.size() - f0, 2);
        tick(2);

        // two-cycle glitch in idle produces no byte
        r0 = rxv_cnt;
        rx = 1'b0; tick(2); rx = 1'b1; tick(40);
        chk("glitch_no_byte", rxv_cnt - r0, 0);

        // ACK while idle is received but dropped
        d0 = done_cnt;
        send_rx(ACK_BYTE, 1'b1);
        tick(4);
        chk("idle_ack_rx", rxv_cnt - r0, 1);
        chk("idle_ack_no_done", done_cnt - d0, 0);
        chk("idle_ack_ready", 32'(hif.cmd_ready), 1);

        // cmd_valid held through busy; state change must not leak into the resend
        f0 = tx_bytes.size(); d0 = done_cnt; fl0 = fail_cnt;
        hif.cmd_state = 3'd5; hif.cmd_valid = 1'b1;
        @(negedge clk);
        hif.cmd_state = 3'd1;
        wait_frames(f0 + 1);
        wait_frames(f0 + 2);
        wait_until(tx_starts[f0 + 1] + FRAME + 10);
        send_rx(ACK_BYTE, 1'b1);
        wait_outcome(d0 + fl0);
        chk("hold_byte0", tx_bytes[f0], 8'h35);
        chk("hold_byte1", tx_bytes[f0 + 1], 8'h35);
        chk("hold_done", done_cnt - d0, 1);
        s = 0;
        while (hif.busy !== 1'b1 && s < 20) begin @(negedge clk); s++; end
        hif.cmd_valid = 1'b0;
        chk("hold_reaccept", 32'(hif.busy), 1);
        wait_frames(f0 + 3);
        chk("hold_byte2", tx_bytes[f0 + 2], 8'h31);
        wait_until(tx_starts[f0 + 2] + FRAME + 3);
        send_rx(ACK_BYTE, 1'b1);
        wait_outcome(d0 + fl0 + 1);
        chk("hold_done2", done_cnt - d0, 2);
        tick(2);

        // reset in the middle of the data bits
        f0 = tx_bytes.size(); d0 = done_cnt; fl0 = fail_cnt;
        hif.cmd_state = 3'd6; hif.cmd_valid = 1'b1;
        @(negedge clk);
        hif.cmd_valid = 1'b0;
        wait_until(cyc + 30);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx), 1);
        chk("midrst_ready", 32'(hif.cmd_ready), 1);
        chk("midrst_busy", 32'(hif.busy), 0);
        tick(3);
        rst_n = 1'b1;
        tick(FRAME + AT + 50);
        chk("midrst_frames", tx_bytes.size() - f0, 0);
        chk("midrst_done", done_cnt - d0, 0);
        chk("midrst_fail", fail_cnt - fl0, 0);
        chk("midrst_tx_idle", 32'(tx), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
